// File: rtl/vga_timing_gen.sv
// 800x480 video timing generator: H/V counters, sync/blank generation and
// pixel pops from a show-ahead FIFO, with all video outputs registered.
module vga_timing_gen #(
  parameter int HDISP  = 800,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VDISP  = 480,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst_n,
  input  logic        fifo_ready,
  input  logic        fifo_empty,
  input  logic [23:0] fifo_rdata,
  output logic        fifo_read,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank,
  output logic [23:0] vga_rgb,
  output logic        underflow
);
  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);

  localparam logic [HW-1:0] H_DISP = HW'(HDISP);
  localparam logic [HW-1:0] H_SS   = HW'(HDISP + HFP);
  localparam logic [HW-1:0] H_SE   = HW'(HDISP + HFP + HPULSE);
  localparam logic [HW-1:0] H_MAX  = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_DISP = VW'(VDISP);
  localparam logic [VW-1:0] V_SS   = VW'(VDISP + VFP);
  localparam logic [VW-1:0] V_SE   = VW'(VDISP + VFP + VPULSE);
  localparam logic [VW-1:0] V_MAX  = VW'(VTOTAL - 1);

  typedef enum logic {WAIT_FILL, RUN} state_t;

  state_t        state;
  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          active, h_sync, v_sync, h_wrap, v_wrap;

  assign active    = (state == RUN) && (hcnt < H_DISP) && (vcnt < V_DISP);
  assign fifo_read = active && !fifo_empty;
  assign h_sync    = (hcnt >= H_SS) && (hcnt < H_SE);
  assign v_sync    = (vcnt >= V_SS) && (vcnt < V_SE);
  assign h_wrap    = (hcnt == H_MAX);
  assign v_wrap    = (vcnt == V_MAX);

  // Outputs only advance in RUN, so they keep reset values while waiting for fill.
  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      state     <= WAIT_FILL;
      hcnt      <= '0;
      vcnt      <= '0;
      vga_hs    <= 1'b1;
      vga_vs    <= 1'b1;
      vga_blank <= 1'b0;
      vga_rgb   <= '0;
      underflow <= 1'b0;
    end else begin
      case (state)
        WAIT_FILL: if (fifo_ready) state <= RUN;
        RUN: begin
          hcnt <= h_wrap ? '0 : hcnt + HW'(1);
          if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + VW'(1);
          vga_hs    <= !h_sync;
          vga_vs    <= !v_sync;
          vga_blank <= active;
          vga_rgb   <= fifo_read ? fifo_rdata : '0;
          // An empty FIFO on a display pixel shows black; timing never stalls.
          if (active && fifo_empty) underflow <= 1'b1;
        end
        default: state <= WAIT_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster; a time-based model predicts
// every output each cycle, plus literal checks of line/frame counts.
module tb_vga_timing_gen;
  localparam int HDISP = 16, HFP = 3, HPULSE = 4, HBP = 5;
  localparam int VDISP = 6, VFP = 2, VPULSE = 3, VBP = 4;
  localparam int HT = HDISP + HFP + HPULSE + HBP;  // 28
  localparam int VT = VDISP + VFP + VPULSE + VBP;  // 15
  localparam int FRAME = HT * VT;                  // 420

  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n, fifo_ready, fifo_empty;
  logic [23:0] fifo_rdata;
  logic        fifo_read, vga_hs, vga_vs, vga_blank, underflow;
  logic [23:0] vga_rgb;

  vga_timing_gen #(
    .HDISP(HDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VDISP(VDISP), .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .fifo_ready(fifo_ready),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_read(fifo_read),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank(vga_blank), .vga_rgb(vga_rgb),
    .underflow(underflow)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position is a pure function of cycles elapsed since RUN began.
  function automatic bit act_at(int unsigned tt);
    return (tt % HT) < HDISP && ((tt / HT) % VT) < VDISP;
  endfunction
  function automatic bit hs_at(int unsigned tt);
    int unsigned x = tt % HT;
    return x >= HDISP + HFP && x < HDISP + HFP + HPULSE;
  endfunction
  function automatic bit vs_at(int unsigned tt);
    int unsigned y = (tt / HT) % VT;
    return y >= VDISP + VFP && y < VDISP + VFP + VPULSE;
  endfunction

  bit          running = 0;
  int unsigned t = 0;
  bit          e_hs = 1, e_vs = 1, e_blank = 0, e_uf = 0;
  logic [23:0] e_rgb = '0;

  initial forever begin
    @(posedge pixel_clk or negedge pixel_rst_n);
    if (!pixel_rst_n) begin
      running = 0; t = 0; e_hs = 1; e_vs = 1; e_blank = 0; e_rgb = '0; e_uf = 0;
    end else if (!running) begin
      if (fifo_ready) begin running = 1; t = 0; end
    end else begin
      e_blank = act_at(t);
      e_hs    = !hs_at(t);
      e_vs    = !vs_at(t);
      e_rgb   = (act_at(t) && !fifo_empty) ? fifo_rdata : 24'h0;
      if (act_at(t) && fifo_empty) e_uf = 1;
      t++;
    end
  end

  // Per-cycle compare plus first-frame statistics.
  bit meas = 0;
  int pops = 0, hs_low = 0, vs_low = 0, blanks = 0, first_hs = -1, first_vs = -1;

  initial forever begin
    @(negedge pixel_clk);
    chk("fifo_read", 32'(fifo_read), 32'(running && act_at(t) && !fifo_empty));
    chk("vga_hs", 32'(vga_hs), 32'(e_hs));
    chk("vga_vs", 32'(vga_vs), 32'(e_vs));
    chk("vga_blank", 32'(vga_blank), 32'(e_blank));
    chk("vga_rgb", 32'(vga_rgb), 32'(e_rgb));
    chk("underflow", 32'(underflow), 32'(e_uf));
    if (meas && running) begin
      if (t < FRAME && fifo_read) pops++;
      if (t >= 1 && t <= FRAME) begin
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (vga_blank) blanks++;
        if (!vga_hs && first_hs < 0) first_hs = int'(t);
        if (!vga_vs && first_vs < 0) first_vs = int'(t);
      end
    end
  end

  bit uf_en = 0;

  task automatic step();
    @(posedge pixel_clk);
    #1;
    fifo_rdata = 24'($urandom());
    fifo_empty = uf_en && running && (t % HT) == 10 && ((t / HT) % VT) == 5;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_read"}, 32'(fifo_read), 0);
    chk({tag, "_hs"}, 32'(vga_hs), 1);
    chk({tag, "_vs"}, 32'(vga_vs), 1);
    chk({tag, "_blank"}, 32'(vga_blank), 0);
    chk({tag, "_rgb"}, 32'(vga_rgb), 0);
    chk({tag, "_uf"}, 32'(underflow), 0);
  endtask

  initial begin
    pixel_rst_n = 1; fifo_ready = 0; fifo_empty = 0; fifo_rdata = '0;
    #2 pixel_rst_n = 0;
    #1 chk_reset_vals("por");
    repeat (3) @(posedge pixel_clk);
    #1 pixel_rst_n = 1;

    repeat (2000) step();  // FIFO not ready: outputs must stay idle

    fifo_ready = 1; meas = 1;
    @(negedge pixel_clk) chk("read_before_run", 32'(fifo_read), 0);
    step();
    @(negedge pixel_clk) chk("first_read", 32'(fifo_read), 1);
    repeat (40) step();
    fifo_ready = 0;  // ignored in RUN
    repeat (10) step();
    fifo_ready = 1;
    repeat (5) step();
    fifo_ready = 0;
    while (t < FRAME + 5) step();
    chk("frame_pops", 32'(pops), 96);
    chk("frame_blank", 32'(blanks), 96);
    chk("frame_hs_low", 32'(hs_low), 60);
    chk("frame_vs_low", 32'(vs_low), 84);
    chk("first_hs_low", 32'(first_hs), 20);
    chk("first_vs_low", 32'(first_vs), 225);
    meas = 0;

    // Underflow at pixel (10,5) of the second frame: t = 420 + 5*28 + 10 = 570.
    uf_en = 1;
    while (t < 570) step();
    @(negedge pixel_clk) chk("uf_no_pop", 32'(fifo_read), 0);
    step();
    uf_en = 0;
    @(negedge pixel_clk);
    chk("uf_rgb", 32'(vga_rgb), 0);
    chk("uf_blank", 32'(vga_blank), 1);
    chk("uf_flag", 32'(underflow), 1);
    while (t < 2 * FRAME + 20) step();
    chk("uf_sticky", 32'(underflow), 1);

    // Asynchronous reset mid-line on an active line.
    while ((t % HT) != 8) step();
    chk("pre_rst_blank", 32'(vga_blank), 1);
    pixel_rst_n = 0;
    #2 chk_reset_vals("async_rst");
    repeat (3) @(posedge pixel_clk);
    #1 pixel_rst_n = 1;
    repeat (20) step();
    chk("wait_refill_read", 32'(fifo_read), 0);
    fifo_ready = 1;
    step();
    fifo_ready = 0;
    @(negedge pixel_clk) chk("restart_read", 32'(fifo_read), 1);
    while (t < FRAME + 10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Pixel-clock-domain video output stage. Generates the 800x480 display timing (HS, VS, BLANK) from horizontal/vertical counters, pops one pixel per active cycle from the show-ahead pixel FIFO filled by the SDRAM reader, and drives registered RGB to the video connector. It sits directly downstream of the pixel FIFO read port and runs on the 32 MHz `pixel_clk` produced by the system PLL.

## Interface
Parameters:
- `HDISP`, 800, active pixels per line
- `HFP`, 40, horizontal front porch (pixels)
- `HPULSE`, 48, horizontal sync pulse width
- `HBP`, 40, horizontal back porch
- `VDISP`, 480, active lines per frame
- `VFP`, 13, vertical front porch (lines)
- `VPULSE`, 3, vertical sync pulse width
- `VBP`, 29, vertical back porch

Ports:
- `pixel_clk`  in  1  pixel clock, 32 MHz; sole clock
- `pixel_rst_n`  in  1  asynchronous, active-low reset
- `fifo_ready`  in  1  FIFO has reached its almost-full level; already in `pixel_clk` domain
- `fifo_empty`  in  1  FIFO read side empty
- `fifo_rdata`  in  24  show-ahead pixel {R[23:16],G[15:8],B[7:0]}
- `fifo_read`  out  1  pop request, combinational
- `vga_hs`  out  1  horizontal sync, active low, registered
- `vga_vs`  out  1  vertical sync, active low, registered
- `vga_blank`  out  1  high while a displayed pixel is being output, registered
- `vga_rgb`  out  24  pixel colour, registered, zero outside display
- `underflow`  out  1  sticky flag, FIFO was empty on a required pop

## Operation
- `HTOTAL = HDISP+HFP+HPULSE+HBP` (928); `VTOTAL = VDISP+VFP+VPULSE+VBP` (525). Counter widths are `$clog2(HTOTAL)` and `$clog2(VTOTAL)`.
- Horizontal regions by `hcnt`: display [0,HDISP), front porch [HDISP,HDISP+HFP), sync [HDISP+HFP,HDISP+HFP+HPULSE), back porch up to HTOTAL-1. Vertical regions by `vcnt` follow the same order.
- FSM states:
  - WAIT_FILL, the reset state. Counters are held at 0, `fifo_read` is 0, and the outputs hold their reset values. Moves to RUN on the first cycle with `fifo_ready`=1.
  - RUN. Never returns to WAIT_FILL except through reset.
- In RUN, `hcnt` increments every cycle and wraps HTOTAL-1 to 0. `vcnt` increments when `hcnt` wraps, and wraps VTOTAL-1 to 0 at the same time as `hcnt`.
- `active = RUN && hcnt<HDISP && vcnt<VDISP`.
- `fifo_read = active && !fifo_empty`.
- Underflow (`active && fifo_empty`): no pop, `vga_rgb` gets 0 for that pixel, `underflow` is set to 1. The counters do not stall.
- `underflow` clears only on reset.
- `fifo_ready` is ignored once the block is in RUN.

## Timing
- Every registered output appears 1 cycle after the counter value that produced it.
  - `vga_hs`=0 in the cycle after `hcnt`∈sync.
  - `vga_vs`=0 in the cycle after `vcnt`∈sync. VS is evaluated per cycle, so its edges coincide with the line start (hcnt=0).
  - `vga_blank` = registered `active`.
  - `vga_rgb` = registered (`fifo_read` ? `fifo_rdata` : 0).
- Pixel (x,y) is popped while hcnt=x, vcnt=y, and is on `vga_rgb` in the next cycle.
- Per-frame totals in RUN: exactly HDISP×VDISP pops (384000) when the FIFO never empties; frame period 928×525 cycles.
- Reset values (assertion asynchronous, deassertion clocked by `pixel_clk`):
  - state WAIT_FILL; `hcnt`=`vcnt`=0
  - `vga_hs`=1, `vga_vs`=1, `vga_blank`=0, `vga_rgb`=0, `underflow`=0
  - `fifo_read` is 0 because the state is WAIT_FILL
- Reset mid-frame: all of the above take effect immediately. After release the block waits for `fifo_ready` again.
- First RUN cycle: hcnt=0, vcnt=0, so the first pop happens in the cycle after `fifo_ready` is sampled high.

## Test plan
- Reset, then hold `fifo_ready`=0 for 2000 cycles -> `fifo_read`=0, `vga_hs`=`vga_vs`=1, `vga_blank`=0, `vga_rgb`=0 throughout.
- Assert `fifo_ready`, keep FIFO non-empty with an incrementing pattern -> first `fifo_read` 1 cycle after `fifo_ready`. Per line: 800 pops, `vga_hs` low for exactly 48 cycles starting 841 cycles after line start. Period 928.
- Run a full frame -> `vga_vs` low for 3×928 cycles starting at line 493. 384000 pops per frame. Frame period 487200 cycles. `vga_rgb` equals the popped data 1 cycle later, and is 0 whenever `vga_blank`=0.
- Force `fifo_empty`=1 for pixel (10,5) only -> no pop that cycle, `vga_rgb`=0 next cycle with `vga_blank`=1, `underflow`=1 and still 1 after frame end. Counters unshifted: the next line starts 928 cycles after the previous one.
- Assert `pixel_rst_n`=0 mid-line (hcnt≈400) -> outputs take reset values with no clock edge. After release: waits for `fifo_ready`, then restarts at hcnt=vcnt=0.
- Toggle `fifo_ready` to 0 while in RUN -> timing continues unaffected.
